// File: rtl/pb_pkg.sv
// Shared types and default timing constants for the pushbutton array processor.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } pb_state_t;

  localparam int DEF_N_CH        = 2;
  localparam int DEF_DEBOUNCE_MS = 5;
  localparam int DEF_LONG_MS     = 1000;
  localparam int DEF_REPEAT_MS   = 200;

endpackage

// File: rtl/pb_channel.sv
// One button channel: 2-flop synchroniser, debounce, press classifier FSM and timers.
// Define PB_AUTOREPEAT_EN to build the auto-repeat counter; otherwise repeat_pulse_o is tied low.
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS
`ifdef PB_AUTOREPEAT_EN
  ,parameter int REPEAT_MS  = DEF_REPEAT_MS
`endif
) (
  input  logic clk_1khz_i,
  input  logic rst_n_i,
  input  logic button_i,
  output logic pressed_o,
  output logic short_pulse_o,
  output logic long_pulse_o,
  output logic repeat_pulse_o
);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);

  logic          sync_q1, sync_q2;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          pressed_d;
  logic [HW-1:0] hold_q, hold_d;
  pb_state_t     state_q, state_d;
  logic          short_d, long_d;

  // The FSM looks at the next debounced level so it moves on the same edge pressed_o does.
  always_comb begin
    pressed_d = pressed_o;
    db_cnt_d  = '0;
    if (sync_q2 != pressed_o) begin
      if (db_cnt_q == DB_LAST) pressed_d = sync_q2;
      else                     db_cnt_d  = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_d) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!pressed_d) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = LONG_HELD;
          hold_d  = HOLD_MAX;
          long_d  = 1'b1;
        end else begin
          hold_d  = hold_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!pressed_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      db_cnt_q      <= '0;
      pressed_o     <= 1'b0;
      hold_q        <= '0;
      state_q       <= IDLE;
      short_pulse_o <= 1'b0;
      long_pulse_o  <= 1'b0;
    end else begin
      sync_q1       <= button_i;
      sync_q2       <= sync_q1;
      db_cnt_q      <= db_cnt_d;
      pressed_o     <= pressed_d;
      hold_q        <= hold_d;
      state_q       <= state_d;
      short_pulse_o <= short_d;
      long_pulse_o  <= long_d;
    end
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_MS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_MS - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_pulse_d;

  // Counter sits at zero outside LONG_HELD, so the first repeat lands REPEAT_MS after the long pulse.
  always_comb begin
    rep_cnt_d   = '0;
    rep_pulse_d = 1'b0;
    if (state_q == LONG_HELD && pressed_d) begin
      if (rep_cnt_q == REP_LAST) rep_pulse_d = 1'b1;
      else                       rep_cnt_d   = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_cnt_q      <= '0;
      repeat_pulse_o <= 1'b0;
    end else begin
      rep_cnt_q      <= rep_cnt_d;
      repeat_pulse_o <= rep_pulse_d;
    end
  end
`else
  assign repeat_pulse_o = 1'b0;
`endif

endmodule

// File: rtl/pushbutton_array_processor.sv
// Array of N_CH independent debounced pushbutton channels with short/long/repeat press pulses.
// Define PB_AUTOREPEAT_EN to enable auto-repeat pulses during long holds.
module pushbutton_array_processor
  import pb_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic            clk_1khz_i,
  input  logic            rst_n_i,
  input  logic [N_CH-1:0] button_i,
  output logic [N_CH-1:0] pressed_o,
  output logic [N_CH-1:0] short_pulse_o,
  output logic [N_CH-1:0] long_pulse_o,
  output logic [N_CH-1:0] repeat_pulse_o
);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
`ifdef PB_AUTOREPEAT_EN
      ,.REPEAT_MS  (REPEAT_MS)
`endif
    ) u_channel (
      .clk_1khz_i     (clk_1khz_i),
      .rst_n_i        (rst_n_i),
      .button_i       (button_i[ch]),
      .pressed_o      (pressed_o[ch]),
      .short_pulse_o  (short_pulse_o[ch]),
      .long_pulse_o   (long_pulse_o[ch]),
      .repeat_pulse_o (repeat_pulse_o[ch])
    );
  end

endmodule

// File: tb/tb_pushbutton_array_processor.sv
// Self-checking bench for pushbutton_array_processor against a window/timing reference model.
module tb_pushbutton_array_processor;

  localparam int N_CH = 2;
  localparam int D    = 5;
  localparam int LONG = 1000;
  localparam int REP  = 200;
  localparam int HLEN = D + 2;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] pressed_o, short_pulse_o, long_pulse_o, repeat_pulse_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: raw sample history, debounced level, rise time per channel
  bit              hist [N_CH][HLEN];
  logic [N_CH-1:0] m_pressed;
  int              rise_t [N_CH];

  // Observed pulse bookkeeping for scenario-level checks
  int   short_cnt [N_CH];
  int   long_cnt  [N_CH];
  int   rep_cnt   [N_CH];
  int   long_cyc  [N_CH];
  int   rep_cyc   [N_CH][$];
  logic [N_CH-1:0] pressed_seen;

  pushbutton_array_processor #(
    .N_CH        (N_CH),
    .DEBOUNCE_MS (D),
    .LONG_MS     (LONG),
    .REPEAT_MS   (REP)
  ) dut (
    .clk_1khz_i     (clk),
    .rst_n_i        (rst_n),
    .button_i       (button),
    .pressed_o      (pressed_o),
    .short_pulse_o  (short_pulse_o),
    .long_pulse_o   (long_pulse_o),
    .repeat_pulse_o (repeat_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int i = 0; i < HLEN; i++) hist[c][i] = 1'b0;
      rise_t[c] = 0;
    end
    m_pressed = '0;
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) begin
      short_cnt[c] = 0;
      long_cnt[c]  = 0;
      rep_cnt[c]   = 0;
      long_cyc[c]  = -1;
      rep_cyc[c].delete();
    end
    pressed_seen = '0;
  endtask

  // One clock: advance model with the sample taken at this edge, then compare all outputs.
  task automatic tick();
    logic [N_CH-1:0] es, el, er;
    int age;
    bit all_diff;
    @(posedge clk);
    #1;
    cyc++;
    es = '0; el = '0; er = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        for (int i = 0; i < HLEN - 1; i++) hist[c][i] = hist[c][i+1];
        hist[c][HLEN-1] = button[c];
        all_diff = 1'b1;
        for (int i = 0; i < D; i++) if (hist[c][i] == m_pressed[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_pressed[c] = ~m_pressed[c];
          if (m_pressed[c]) rise_t[c] = cyc;
          else if (cyc - rise_t[c] <= LONG) es[c] = 1'b1;
        end else if (m_pressed[c]) begin
          age = cyc - rise_t[c];
          if (age == LONG) el[c] = 1'b1;
`ifdef PB_AUTOREPEAT_EN
          if (age > LONG && ((age - LONG) % REP) == 0) er[c] = 1'b1;
`endif
        end
      end
    end
    check_output("pressed", 32'(pressed_o), 32'(m_pressed));
    check_output("short", 32'(short_pulse_o), 32'(es));
    check_output("long", 32'(long_pulse_o), 32'(el));
    check_output("repeat", 32'(repeat_pulse_o), 32'(er));
    for (int c = 0; c < N_CH; c++) begin
      if (short_pulse_o[c] === 1'b1) short_cnt[c]++;
      if (long_pulse_o[c] === 1'b1) begin
        long_cnt[c]++;
        long_cyc[c] = cyc;
      end
      if (repeat_pulse_o[c] === 1'b1) begin
        rep_cnt[c]++;
        rep_cyc[c].push_back(cyc);
      end
    end
    pressed_seen = pressed_seen | pressed_o;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_stimulus(input logic [N_CH-1:0] val, input int n);
    button = val;
    run(n);
  endtask

  initial begin
    int t0, rel_t, h;
    rst_n  = 1'b0;
    button = '0;
    model_reset();
    clear_counts();

    // Reset state
    run(3);
    check_output("reset_pressed", 32'(pressed_o), 32'd0);
    check_output("reset_pulses", 32'(short_pulse_o | long_pulse_o | repeat_pulse_o), 32'd0);
    rst_n = 1'b1;
    run(5);

    // Bouncy short press on ch0
    clear_counts();
    apply_stimulus(2'b01, 1);
    apply_stimulus(2'b00, 1);
    apply_stimulus(2'b01, 2);
    apply_stimulus(2'b00, 1);
    apply_stimulus(2'b01, 25);
    apply_stimulus(2'b00, 1);
    apply_stimulus(2'b01, 1);
    apply_stimulus(2'b00, 1);
    apply_stimulus(2'b01, 1);
    apply_stimulus(2'b00, 30);
    check_output("bounce_short_cnt", 32'(short_cnt[0]), 32'd1);
    check_output("bounce_long_cnt", 32'(long_cnt[0]), 32'd0);

    // Short glitches on ch1
    clear_counts();
    apply_stimulus(2'b10, 1);
    apply_stimulus(2'b00, 10);
    apply_stimulus(2'b10, 3);
    apply_stimulus(2'b00, 10);
    check_output("glitch_pressed", 32'(pressed_seen[1]), 32'd0);
    check_output("glitch_pulses", 32'(short_cnt[1] + long_cnt[1]), 32'd0);

    // Long hold on ch0
    clear_counts();
    t0 = cyc;
    apply_stimulus(2'b01, 1600);
    apply_stimulus(2'b00, 20);
    check_output("long_cnt", 32'(long_cnt[0]), 32'd1);
    check_output("long_time", 32'(long_cyc[0]), 32'(t0 + LONG + D + 2));
    check_output("long_no_short", 32'(short_cnt[0]), 32'd0);
`ifdef PB_AUTOREPEAT_EN
    check_output("repeat_cnt", 32'(rep_cnt[0]), 32'd2);
    if (rep_cnt[0] == 2) begin
      check_output("repeat_t1", 32'(rep_cyc[0][0]), 32'(long_cyc[0] + REP));
      check_output("repeat_t2", 32'(rep_cyc[0][1]), 32'(long_cyc[0] + 2 * REP));
    end
`else
    check_output("repeat_cnt", 32'(rep_cnt[0]), 32'd0);
`endif

    // Simultaneous short on ch0 and long on ch1
    clear_counts();
    t0 = cyc;
    apply_stimulus(2'b11, 30);
    apply_stimulus(2'b10, 1070);
    apply_stimulus(2'b00, 20);
    check_output("sim_short0", 32'(short_cnt[0]), 32'd1);
    check_output("sim_long0", 32'(long_cnt[0]), 32'd0);
    check_output("sim_long1", 32'(long_cnt[1]), 32'd1);
    check_output("sim_short1", 32'(short_cnt[1]), 32'd0);
    check_output("sim_long1_time", 32'(long_cyc[1]), 32'(t0 + LONG + D + 2));

    // Reset in the middle of a hold
    clear_counts();
    apply_stimulus(2'b01, 500);
    check_output("pre_reset_pressed", 32'(pressed_o[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_reset_pressed", 32'(pressed_o), 32'd0);
    check_output("async_reset_pulses", 32'(short_pulse_o | long_pulse_o | repeat_pulse_o), 32'd0);
    run(2);
    rst_n = 1'b1;
    rel_t = cyc;
    run(1100);
    apply_stimulus(2'b00, 20);
    check_output("rst_long_cnt", 32'(long_cnt[0]), 32'd1);
    check_output("rst_long_time", 32'(long_cyc[0]), 32'(rel_t + LONG + D + 2));
    check_output("rst_no_short", 32'(short_cnt[0]), 32'd0);

    // Hold length right at the short/long boundary on ch1
    clear_counts();
    h = int'($urandom_range(LONG - 2, LONG + 2));
    apply_stimulus(2'b10, h);
    apply_stimulus(2'b00, 20);
    check_output("boundary_long", 32'(long_cnt[1]), (h > LONG) ? 32'd1 : 32'd0);
    check_output("boundary_short", 32'(short_cnt[1]), (h > LONG) ? 32'd0 : 32'd1);

    // Randomised bouncing and holds on all channels
    for (int k = 0; k < 60; k++) begin
      apply_stimulus(N_CH'($urandom_range(0, (1 << N_CH) - 1)), int'($urandom_range(1, 12)));
      if ((k % 15) == 0)
        apply_stimulus(N_CH'($urandom_range(1, (1 << N_CH) - 1)), int'($urandom_range(20, 60)));
    end
    apply_stimulus('0, 20);
    check_output("final_idle", 32'(pressed_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pushbutton_array_processor.md
PUSHBUTTON_ARRAY_PROCESSOR -- requirements
Module: pushbutton_array_processor

Interface
REQ-001 Parameter N_CH, default 2, number of independent button channels (1..8).
REQ-002 Parameter DEBOUNCE_MS, default 5, clock cycles an input must be stable before the debounced level changes (>=1).
REQ-003 Parameter LONG_MS, default 1000, hold time in cycles that classifies a press as long (> DEBOUNCE_MS).
REQ-004 Parameter REPEAT_MS, default 200, auto-repeat interval in cycles (>=1; used only with PB_AUTOREPEAT_EN).
REQ-005 clk_1khz_i  input  1  system clock, 1 kHz, rising-edge active.
REQ-006 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 button_i  input  N_CH  raw asynchronous bouncing button levels, 1 = pressed.
REQ-008 pressed_o  output  N_CH  debounced button level per channel.
REQ-009 short_pulse_o  output  N_CH  one-cycle pulse per completed short press.
REQ-010 long_pulse_o  output  N_CH  one-cycle pulse when a hold reaches LONG_MS.
REQ-011 repeat_pulse_o  output  N_CH  one-cycle auto-repeat pulses during a long hold.

Function
REQ-012 Each channel SHALL be processed independently; no channel's state SHALL affect another.
REQ-013 Each button_i bit SHALL pass a 2-flop synchroniser before any other logic.
REQ-014 Debounce: counter increments while synchronised input differs from pressed_o, clears when equal; on reaching DEBOUNCE_MS-1 with mismatch, pressed_o SHALL take the synchronised value and the counter SHALL clear.
REQ-015 Latency: a clean input edge SHALL appear on pressed_o exactly DEBOUNCE_MS+2 cycles later; any glitch shorter than DEBOUNCE_MS cycles SHALL not change pressed_o.
REQ-016 Per-channel FSM states IDLE, PRESSED, LONG_HELD; IDLE->PRESSED when pressed_o rises; PRESSED->LONG_HELD when hold counter reaches LONG_MS; PRESSED->IDLE or LONG_HELD->IDLE when pressed_o falls.
REQ-017 Hold counter SHALL clear on entry to PRESSED, count once per cycle, width $clog2(LONG_MS+1), saturating at LONG_MS (no wrap).
REQ-018 long_pulse_o SHALL be high for exactly one cycle, the cycle the FSM enters LONG_HELD (LONG_MS cycles after pressed_o rose), once per press.
REQ-019 short_pulse_o SHALL be high for exactly one cycle, the first cycle after a PRESSED->IDLE transition; LONG_HELD->IDLE SHALL produce no pulse.
REQ-020 short_pulse_o and long_pulse_o of one channel SHALL never be high in the same cycle; all pulse outputs SHALL be registered.

Reset
REQ-021 Asserting rst_n_i low SHALL immediately clear synchronisers, counters, pressed_o and all pulse outputs to 0 and force every FSM to IDLE.
REQ-022 Reset mid-press SHALL discard the press; a button still held at release of reset SHALL be treated as a new press after DEBOUNCE_MS+2 cycles.

Configuration
REQ-023 Macro PB_AUTOREPEAT_EN defined: in LONG_HELD a repeat counter SHALL emit repeat_pulse_o for one cycle every REPEAT_MS cycles after the long pulse, stopping on release.
REQ-024 PB_AUTOREPEAT_EN undefined: repeat_pulse_o SHALL remain present and tied to 0; no repeat counter logic synthesised.

Structure
REQ-025 Shared package pb_pkg SHALL hold the FSM state typedef (IDLE, PRESSED, LONG_HELD) and default timing constants.
REQ-026 A sub-module pb_channel SHALL implement one channel (sync, debounce, FSM, timers); the top SHALL instantiate N_CH copies via generate.

Verification
REQ-027 Defaults; ch0 bounce 1,0(1),1(2),0(1),1 then hold 25 cycles, bounce on release -> exactly one short_pulse_o[0], no long pulse.
REQ-028 ch0 held 1600 cycles -> long_pulse_o[0] once, LONG_MS+DEBOUNCE_MS+2 = 1007 cycles after press; no short pulse on release.
REQ-029 1-cycle and 3-cycle glitches on ch1 -> pressed_o[1] stays 0, no pulses.
REQ-030 ch0 short and ch1 long pressed simultaneously -> short on ch0 only, long on ch1 only, timing per REQ-027/028.
REQ-031 rst_n_i low for 2 cycles at hold cycle 500 -> all outputs 0 at once; no long pulse at the original 1007 mark; next long pulse 1007 cycles after reset release.
REQ-032 PB_AUTOREPEAT_EN, REPEAT_MS=200, 1600-cycle hold -> repeat pulses at long-pulse+200 and +400, none after release.
